// File: rtl/ball_object.sv
// ball_object: a rectangle sprite that moves once per frame with a signed
// velocity, freezes (and blinks) for a number of frames after a hit, and
// draws itself with a registered drawingRequest and RGB.
// Edge behaviour is selected by the macro BORDER_BOUNCE_EN. When it is
// defined, the object is clamped at the edge and that velocity component
// is negated. When it is undefined, the position wraps and the velocity
// is left unchanged.
module ball_object #(
    parameter int          OBJ_W         = 32,
    parameter int          OBJ_H         = 32,
    parameter int          INIT_X        = 304,
    parameter int          INIT_Y        = 224,
    parameter int          INIT_VX       = 3,
    parameter int          INIT_VY       = -2,
    parameter int          FREEZE_FRAMES = 30,
    parameter logic [7:0]  OBJ_R         = 8'hFF,
    parameter logic [7:0]  OBJ_G         = 8'h40,
    parameter logic [7:0]  OBJ_B         = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startOfFrame,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        enable,
    input  logic        hit,
    output logic        drawingRequest,
    output logic [7:0]  Red,
    output logic [7:0]  Green,
    output logic [7:0]  Blue,
    output logic [10:0] topLeftX,
    output logic [10:0] topLeftY,
    output logic        frozen
);

    localparam logic signed [11:0] X_MAX = 12'(640 - OBJ_W);
    localparam logic signed [11:0] Y_MAX = 12'(480 - OBJ_H);

    typedef enum logic [1:0] {STOPPED, MOVING, FROZEN} state_t;

    typedef struct packed {
        logic signed [11:0] v;
        logic [10:0]        p;
    } axis_t;

    state_t             state_q, state_d;
    logic [10:0]        x_q, x_d, y_q, y_d;
    logic signed [11:0] vx_q, vx_d, vy_q, vy_d;
    logic [15:0]        frz_q, frz_d;
    logic [3:0]         frame_q;
    logic               dr_q, dr_d;
    axis_t              ax, ay;

    // One axis of motion: add velocity, then resolve the screen edge.
    function automatic axis_t step_axis(input logic [10:0] pos,
                                        input logic signed [11:0] vel,
                                        input logic signed [11:0] maxv);
        axis_t              r;
        logic signed [11:0] nxt;
        logic signed [11:0] adj;
        nxt = $signed({1'b0, pos}) + vel;
        adj = nxt;
        r.v = vel;
`ifdef BORDER_BOUNCE_EN
        if (nxt < 0) begin
            adj = '0;
            r.v = -vel;
        end else if (nxt > maxv) begin
            adj = maxv;
            r.v = -vel;
        end
`else
        if (nxt < 0) begin
            adj = nxt + maxv + 12'sd1;
        end else if (nxt > maxv) begin
            adj = nxt - maxv - 12'sd1;
        end
`endif
        r.p = adj[10:0];
        return r;
    endfunction

    // Next-state logic: enable gate first, then hit/freeze/move per state.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        vx_d    = vx_q;
        vy_d    = vy_q;
        frz_d   = frz_q;
        ax      = step_axis(x_q, vx_q, X_MAX);
        ay      = step_axis(y_q, vy_q, Y_MAX);
        if (!enable) begin
            state_d = STOPPED;
        end else begin
            case (state_q)
                STOPPED: state_d = MOVING;
                MOVING: begin
                    // hit takes priority over a coincident frame update
                    if (hit) begin
                        state_d = FROZEN;
                        frz_d   = 16'(FREEZE_FRAMES);
                    end else if (startOfFrame) begin
                        x_d  = ax.p;
                        vx_d = ax.v;
                        y_d  = ay.p;
                        vy_d = ay.v;
                    end
                end
                FROZEN: begin
                    if (startOfFrame) begin
                        if (frz_q <= 16'd1) begin
                            frz_d   = '0;
                            state_d = MOVING;
                        end else begin
                            frz_d = frz_q - 16'd1;
                        end
                    end
                end
                default: state_d = STOPPED;
            endcase
        end
    end

    // Pixel hit test; in FROZEN the object blinks on frame counter bit 3.
    always_comb begin
        dr_d = ({1'b0, pixelX} >= {1'b0, x_q}) &&
               ({1'b0, pixelX} <  ({1'b0, x_q} + 12'(OBJ_W))) &&
               ({1'b0, pixelY} >= {1'b0, y_q}) &&
               ({1'b0, pixelY} <  ({1'b0, y_q} + 12'(OBJ_H)));
        if (state_q == FROZEN && frame_q[3]) begin
            dr_d = 1'b0;
        end
    end

    // State, motion, counters and draw register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= STOPPED;
            x_q     <= 11'(INIT_X);
            y_q     <= 11'(INIT_Y);
            vx_q    <= 12'(INIT_VX);
            vy_q    <= 12'(INIT_VY);
            frz_q   <= '0;
            frame_q <= '0;
            dr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            vx_q    <= vx_d;
            vy_q    <= vy_d;
            frz_q   <= frz_d;
            dr_q    <= dr_d;
            if (startOfFrame) begin
                frame_q <= frame_q + 4'd1;
            end
        end
    end

    assign drawingRequest = dr_q;
    assign Red            = dr_q ? OBJ_R : '0;
    assign Green          = dr_q ? OBJ_G : '0;
    assign Blue           = dr_q ? OBJ_B : '0;
    assign topLeftX       = x_q;
    assign topLeftY       = y_q;
    assign frozen         = (state_q == FROZEN);

endmodule

// File: tb/tb_ball_object.sv
// Self-checking bench for ball_object: reset values, the pixel hit test
// (table), movement, edge handling for either BORDER_BOUNCE_EN setting,
// freeze/blink and the enable/reset overrides.
module tb_ball_object;

    logic        clk = 1'b0;
    logic        reset, sof;
    logic [10:0] px, py;
    logic        en0, hit0, en_e, hit_e, en_d, hit_d;

    logic        dr0, dre, drd, fz0, fze, fzd;
    logic [7:0]  r0, g0, b0, re, ge, be, rd, gd, bd;
    logic [10:0] x0, y0, xe, ye, xd, yd;

    int ntests = 0;
    int nfail  = 0;
    int nsof   = 0;

    always #5 clk = ~clk;

    ball_object u_dut (
        .clk(clk), .reset(reset), .startOfFrame(sof), .pixelX(px), .pixelY(py),
        .enable(en0), .hit(hit0), .drawingRequest(dr0), .Red(r0), .Green(g0),
        .Blue(b0), .topLeftX(x0), .topLeftY(y0), .frozen(fz0)
    );

    ball_object #(.INIT_X(606), .INIT_Y(100), .INIT_VX(3), .INIT_VY(0)) u_edge (
        .clk(clk), .reset(reset), .startOfFrame(sof), .pixelX(px), .pixelY(py),
        .enable(en_e), .hit(hit_e), .drawingRequest(dre), .Red(re), .Green(ge),
        .Blue(be), .topLeftX(xe), .topLeftY(ye), .frozen(fze)
    );

    ball_object #(.INIT_X(100), .INIT_Y(50)) u_draw (
        .clk(clk), .reset(reset), .startOfFrame(sof), .pixelX(px), .pixelY(py),
        .enable(en_d), .hit(hit_d), .drawingRequest(drd), .Red(rd), .Green(gd),
        .Blue(bd), .topLeftX(xd), .topLeftY(yd), .frozen(fzd)
    );

    typedef struct {
        logic [10:0] px;
        logic [10:0] py;
        logic        dr;
        logic [23:0] rgb;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        ntests++;
        if (act !== expv) begin
            nfail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle startOfFrame pulse (optionally with hit), then one idle cycle.
    task automatic pulse(input logic h);
        hit0 = h;
        sof  = 1'b1;
        tick();
        sof  = 1'b0;
        hit0 = 1'b0;
        nsof++;
        tick();
    endtask

    initial begin
        logic [31:0] exp_dr;
        logic        exp_fz;

        vecs[0] = '{11'd0,   11'd0,  1'b0, 24'h000000};
        vecs[1] = '{11'd100, 11'd50, 1'b1, 24'hFF4000};
        vecs[2] = '{11'd131, 11'd81, 1'b1, 24'hFF4000};
        vecs[3] = '{11'd132, 11'd50, 1'b0, 24'h000000};
        vecs[4] = '{11'd99,  11'd50, 1'b0, 24'h000000};
        vecs[5] = '{11'd100, 11'd49, 1'b0, 24'h000000};
        vecs[6] = '{11'd100, 11'd81, 1'b1, 24'hFF4000};
        vecs[7] = '{11'd100, 11'd82, 1'b0, 24'h000000};
        vecs[8] = '{11'd115, 11'd60, 1'b1, 24'hFF4000};
        vecs[9] = '{11'd131, 11'd50, 1'b1, 24'hFF4000};

        reset = 1'b1; sof = 1'b0; px = '0; py = '0;
        en0 = 1'b0; hit0 = 1'b0; en_e = 1'b0; hit_e = 1'b0; en_d = 1'b0; hit_d = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset values
        check("rst_x", 32'(x0), 32'd304);
        check("rst_y", 32'(y0), 32'd224);
        check("rst_frozen", 32'(fz0), 32'd0);
        check("rst_dr", 32'(dr0), 32'd0);
        check("rst_rgb", 32'({r0, g0, b0}), 32'd0);
        check("rst_edge_x", 32'(xe), 32'd606);

        // Pixel hit test on a stationary object at (100,50)
        for (int i = 0; i < 10; i++) begin
            px = vecs[i].px;
            py = vecs[i].py;
            if (i == 1) check("dr_latency", 32'(drd), 32'd0);
            tick();
            check($sformatf("draw_dr[%0d]", i), 32'(drd), 32'(vecs[i].dr));
            check($sformatf("draw_rgb[%0d]", i), 32'({rd, gd, bd}), 32'(vecs[i].rgb));
        end

        // First frame of movement and edge handling
        en0 = 1'b1; en_e = 1'b1;
        tick();
        check("stopped_hold_x", 32'(x0), 32'd304);
        pulse(1'b0);
        check("move1_x", 32'(x0), 32'd307);
        check("move1_y", 32'(y0), 32'd222);
`ifdef BORDER_BOUNCE_EN
        check("edge1_x", 32'(xe), 32'd608);
`else
        check("edge1_x", 32'(xe), 32'd0);
`endif
        en0 = 1'b0;
        pulse(1'b0);
`ifdef BORDER_BOUNCE_EN
        check("edge2_x", 32'(xe), 32'd605);
`else
        check("edge2_x", 32'(xe), 32'd3);
`endif
        check("edge_y", 32'(ye), 32'd100);
        check("disabled_hold_x", 32'(x0), 32'd307);
        en_e = 1'b0;
        en0  = 1'b1;
        tick();

        // Hit coincident with frame: no move, freeze for 30 frames, blink
        px = 11'd307; py = 11'd222;
        pulse(1'b1);
        check("hit_x", 32'(x0), 32'd307);
        check("hit_y", 32'(y0), 32'd222);
        check("hit_frozen", 32'(fz0), 32'd1);
        for (int i = 1; i <= 30; i++) begin
            pulse(i == 5);
            exp_fz = (i < 30);
            exp_dr = exp_fz ? 32'(((nsof >> 3) & 1) == 0) : 32'd1;
            check($sformatf("frz_state[%0d]", i), 32'(fz0), 32'(exp_fz));
            check($sformatf("frz_x[%0d]", i), 32'(x0), 32'd307);
            check($sformatf("frz_dr[%0d]", i), 32'(dr0), exp_dr);
        end
        pulse(1'b0);
        check("resume_x", 32'(x0), 32'd310);
        check("resume_y", 32'(y0), 32'd220);

        // enable=0 with 10 freeze frames left
        pulse(1'b1);
        for (int i = 0; i < 20; i++) pulse(1'b0);
        check("frz20_frozen", 32'(fz0), 32'd1);
        en0 = 1'b0;
        tick();
        check("dis_frozen", 32'(fz0), 32'd0);
        check("dis_x", 32'(x0), 32'd310);
        check("dis_y", 32'(y0), 32'd220);
        pulse(1'b0);
        check("stop_hold_x", 32'(x0), 32'd310);
        en0 = 1'b1;
        tick();
        check("reen_frozen", 32'(fz0), 32'd0);
        pulse(1'b0);
        check("reen_x", 32'(x0), 32'd313);
        check("reen_y", 32'(y0), 32'd218);

        // Reset mid-freeze overrides coincident frame and hit
        pulse(1'b1);
        check("pre_rst_frozen", 32'(fz0), 32'd1);
        px = 11'd304; py = 11'd224;
        reset = 1'b1; sof = 1'b1; hit0 = 1'b1;
        tick();
        reset = 1'b0; sof = 1'b0; hit0 = 1'b0;
        nsof = 0;
        check("mid_rst_x", 32'(x0), 32'd304);
        check("mid_rst_y", 32'(y0), 32'd224);
        check("mid_rst_frozen", 32'(fz0), 32'd0);
        check("mid_rst_dr", 32'(dr0), 32'd0);
        check("mid_rst_rgb", 32'({r0, g0, b0}), 32'd0);
        tick();
        check("post_rst_dr", 32'(dr0), 32'd1);
        check("post_rst_rgb", 32'({r0, g0, b0}), 32'hFF4000);
        pulse(1'b0);
        check("post_rst_x", 32'(x0), 32'd307);
        check("post_rst_y", 32'(y0), 32'd222);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
